pipelined_add_sub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake. It is the sequential successor to the team's 4-bit combinational ripple-carry adder. The carry chain is cut into `STAGES` registered chunks so that wide operands close timing at one result per clock. The block sits between operand producers (register file or ALU front end) and any consumer that can apply backpressure.

---
 rtl/pipelined_add_sub_if.sv | 28 ++
 rtl/pipelined_add_sub.sv | 98 +++++++++
 tb/tb_pipelined_add_sub.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for pipelined_add_sub.
// The producer/consumer side takes master; the adder takes slave.
interface pipelined_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
  logic             Zero;

  modport master (
    output in_valid, A, B, Cin, sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf, Zero
  );

  modport slave (
    input  in_valid, A, B, Cin, sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf, Zero
  );
endinterface

// File: rtl/pipelined_add_sub.sv
// Two's-complement adder/subtractor whose carry chain is split into STAGES
// registered chunks, with a single global enable driven by output backpressure.
module pipelined_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic              clk,
  input logic              rst,
  pipelined_add_sub_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  logic             adv;

  logic [WIDTH-1:0] a_r   [STAGES];
  logic [WIDTH-1:0] b_r   [STAGES];
  logic [WIDTH-1:0] s_r   [STAGES];
  logic             c_r   [STAGES];
  logic             v_r   [STAGES];

  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [WIDTH-1:0] s_src [STAGES];
  logic             c_src [STAGES];
  logic             v_src [STAGES];
  logic [WIDTH-1:0] s_nxt [STAGES];
  logic             c_nxt [STAGES];

  logic [CHUNK:0]   part;
  logic             ovf_nxt;
  logic             zero_nxt;
  logic             ovf_r;
  logic             zero_r;

  assign adv           = !v_r[LAST] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v_r[LAST];
  assign bus.Sum       = s_r[LAST];
  assign bus.Cout      = c_r[LAST];
  assign bus.Ovf       = ovf_r;
  assign bus.Zero      = zero_r;

  // Stage 0 sees the live operands (B inverted and carry forced for subtract);
  // later stages see the skewed operands and partial sum of the stage before.
  always_comb begin
    part     = '0;
    a_src[0] = bus.A;
    b_src[0] = bus.sub ? ~bus.B : bus.B;
    s_src[0] = '0;
    c_src[0] = bus.sub ? 1'b1 : bus.Cin;
    v_src[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_r[k-1];
      b_src[k] = b_r[k-1];
      s_src[k] = s_r[k-1];
      c_src[k] = c_r[k-1];
      v_src[k] = v_r[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
           + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
           + (CHUNK+1)'(c_src[k]);
      s_nxt[k] = s_src[k];
      s_nxt[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      c_nxt[k] = part[CHUNK];
    end
    ovf_nxt  = (a_src[LAST][WIDTH-1] == b_src[LAST][WIDTH-1]) &&
               (s_nxt[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);
    zero_nxt = (s_nxt[LAST] == '0);
  end

  // Flags are registered with the final chunk so they clear on reset and
  // hold along with Sum while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
        c_r[k] <= 1'b0;
        v_r[k] <= 1'b0;
      end
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= a_src[k];
        b_r[k] <= b_src[k];
        s_r[k] <= s_nxt[k];
        c_r[k] <= c_nxt[k];
        v_r[k] <= v_src[k];
      end
      ovf_r  <= ovf_nxt;
      zero_r <= zero_nxt;
    end
  end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: a 16-bit/4-stage instance and a
// 4-bit/1-stage instance, checked against hand-computed results.
module tb_pipelined_add_sub;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipelined_add_sub_if #(.WIDTH(16)) bus16 ();
  pipelined_add_sub_if #(.WIDTH(4))  bus4 ();

  pipelined_add_sub #(.WIDTH(16), .STAGES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  pipelined_add_sub #(.WIDTH(4), .STAGES(1)) dut_legacy (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] a,
                               input logic [15:0] b, input logic cin,
                               input logic sb);
    bus16.in_valid = valid;
    bus16.A        = a;
    bus16.B        = b;
    bus16.Cin      = cin;
    bus16.sub      = sb;
  endtask

  // One isolated operation: result must appear exactly 3 edges after the
  // accepting edge and stay valid for one cycle with out_ready held high.
  task automatic runSingle(input string tag, input logic [15:0] a,
                           input logic [15:0] b, input logic cin,
                           input logic sb, input logic [31:0] exp_sum,
                           input logic [31:0] exp_cout,
                           input logic [31:0] exp_ovf,
                           input logic [31:0] exp_zero);
    @(negedge clk);
    applyStimulus(1'b1, a, b, cin, sb);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, "_early"}, 32'(bus16.out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid"}, 32'(bus16.out_valid), 32'd1);
    checkOutput({tag, "_sum"},   32'(bus16.Sum),       exp_sum);
    checkOutput({tag, "_cout"},  32'(bus16.Cout),      exp_cout);
    checkOutput({tag, "_ovf"},   32'(bus16.Ovf),       exp_ovf);
    checkOutput({tag, "_zero"},  32'(bus16.Zero),      exp_zero);
    @(posedge clk);
    #1;
    checkOutput({tag, "_once"},  32'(bus16.out_valid), 32'd0);
  endtask

  initial begin
    logic        stall;
    logic        in_xfer;
    logic        out_xfer;
    logic        any_valid;
    logic [15:0] held;
    int          sent;
    int          recv;

    rst = 1'b1;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    bus16.out_ready = 1'b1;
    bus4.in_valid   = 1'b0;
    bus4.A          = 4'h0;
    bus4.B          = 4'h0;
    bus4.Cin        = 1'b0;
    bus4.sub        = 1'b0;
    bus4.out_ready  = 1'b1;
    held            = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(bus16.out_valid), 32'd0);
    checkOutput("rst_sum",       32'(bus16.Sum),       32'd0);
    checkOutput("rst_cout",      32'(bus16.Cout),      32'd0);
    checkOutput("rst_ovf",       32'(bus16.Ovf),       32'd0);
    checkOutput("rst_zero",      32'(bus16.Zero),      32'd0);
    checkOutput("rst_in_ready",  32'(bus16.in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;

    runSingle("add_basic", 16'h0003, 16'h0005, 1'b0, 1'b0, 32'h0008, 32'd0, 32'd0, 32'd0);
    runSingle("add_cin",   16'h0003, 16'h0005, 1'b1, 1'b0, 32'h0009, 32'd0, 32'd0, 32'd0);
    runSingle("add_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 32'h0000, 32'd1, 32'd0, 32'd1);
    runSingle("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 32'h8000, 32'd0, 32'd1, 32'd0);
    runSingle("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 32'hFFFE, 32'd0, 32'd0, 32'd0);
    runSingle("sub_pos",   16'h0007, 16'h0005, 1'b1, 1'b1, 32'h0002, 32'd1, 32'd0, 32'd0);
    runSingle("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 32'h7FFF, 32'd1, 32'd1, 32'd0);

    // Stream i + 0x0100*i with the consumer stalled on cycles 5..7.
    sent = 0;
    recv = 0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      @(negedge clk);
      stall = (c >= 5 && c <= 7);
      bus16.out_ready = !stall;
      if (sent < 8) applyStimulus(1'b1, 16'(sent), 16'(sent << 8), 1'b0, 1'b0);
      else          applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("in_ready_c%0d", c), 32'(bus16.in_ready), stall ? 32'd0 : 32'd1);
      if (stall) begin
        checkOutput($sformatf("stall_valid_c%0d", c), 32'(bus16.out_valid), 32'd1);
        if (c == 5) held = bus16.Sum;
        else checkOutput($sformatf("stall_hold_c%0d", c), 32'(bus16.Sum), 32'(held));
      end
      in_xfer  = bus16.in_valid && bus16.in_ready;
      out_xfer = bus16.out_valid && bus16.out_ready;
      if (out_xfer) begin
        checkOutput($sformatf("stream_%0d", recv), 32'(bus16.Sum), 32'(recv * 32'h0101));
        recv++;
      end
      if (in_xfer) sent++;
    end
    checkOutput("stream_count", 32'(recv), 32'd8);
    @(negedge clk);
    bus16.out_ready = 1'b1;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stream_drain", 32'(bus16.out_valid), 32'd0);

    // Three ops in flight, then a one-cycle reset must discard all of them.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 16'h0010, 16'(i), 1'b0, 1'b0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus16.out_valid) any_valid = 1'b1;
    end
    checkOutput("rst_flush", 32'(any_valid), 32'd0);
    runSingle("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 32'h2345, 32'd0, 32'd0, 32'd0);

    // Legacy 4-bit single-stage configuration.
    @(negedge clk);
    bus4.in_valid = 1'b1;
    bus4.A        = 4'hB;
    bus4.B        = 4'h7;
    #1;
    checkOutput("leg_pre", 32'(bus4.out_valid), 32'd0);
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    checkOutput("leg_valid", 32'(bus4.out_valid), 32'd1);
    checkOutput("leg_sum",   32'(bus4.Sum),       32'h2);
    checkOutput("leg_cout",  32'(bus4.Cout),      32'd1);
    checkOutput("leg_ovf",   32'(bus4.Ovf),       32'd0);
    checkOutput("leg_zero",  32'(bus4.Zero),      32'd0);
    @(posedge clk);
    #1;
    checkOutput("leg_once",  32'(bus4.out_valid), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
